fs_slot_scheduler: RTL and testbench



---
 rtl/fs_sched_pkg.sv | 15 +
 rtl/fs_rr_arbiter.sv | 35 +++
 rtl/fs_slot_scheduler.sv | 165 ++++++++++++++++
 tb/tb_fs_slot_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_sched_pkg.sv
// fs_sched_pkg: shared types and constants for the fs slot scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fs_sched_pkg;

    typedef enum logic {
        STARTUP = 1'b0,
        RUN     = 1'b1
    } state_t;

    localparam int         PHASE_W     = 8;
    localparam int         FRAME_LEN   = 256;
    localparam logic [7:0] OVR_CNT_MAX = 8'd255;

endpackage

// File: rtl/fs_rr_arbiter.sv
// fs_rr_arbiter: combinational round-robin pick, first set req bit at or after i_ptr, wrapping upward.
// Latency: zero (purely combinational).
// Backpressure: none; the caller decides whether the pick is used.
// Ports: i_ptr search start, i_req request vector, o_win one-hot winner, o_win_idx winner index, o_any any request set.
module fs_rr_arbiter
    import fs_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_win,
    output logic [PTR_W-1:0] o_win_idx,
    output logic             o_any
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_win     = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_win[w_idx] = 1'b1;
                o_win_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/fs_slot_scheduler.sv
// fs_slot_scheduler: tracks the 256-cycle frame phase and shares one resource round-robin among N_REQ requesters.
// Latency: req sampled at edge k -> grant at edge k+1; grant drops the edge after done; at least one idle cycle between grants.
// Backpressure: req is a level held until served; no grant during STARTUP or in the last GUARD cycles of a frame.
// Ports: i_clk_256fs clock, i_rst sync active-high reset, i_req/i_done per requester;
//        o_grant one-hot, o_strobe_fs at phase 0, o_phase, o_ready (RUN), o_overrun sticky, o_overrun_cnt saturating.
// Optional: define FS_SCHED_STATS_EN to add o_busy_cycles (granted cycles of the previous frame).
module fs_slot_scheduler
    import fs_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int STARTUP_FRAMES = 64,
    parameter int GUARD          = 8
) (
    input  logic               i_clk_256fs,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_done,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_strobe_fs,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_ready,
    output logic               o_overrun,
    output logic [7:0]         o_overrun_cnt
`ifdef FS_SCHED_STATS_EN
    ,
    output logic [8:0]         o_busy_cycles
`endif
);

    localparam int PTR_W      = $clog2(N_REQ);
    localparam int OPEN_LIMIT = FRAME_LEN - GUARD;

    state_t             r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic               r_strobe;
    logic [7:0]         r_frame_cnt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]   r_served;   // grants that started in the current frame
    logic [N_REQ-1:0]   r_seen;     // requests seen while a grant could still start this frame
    logic               r_overrun;
    logic [7:0]         r_ovr_cnt;

    logic               w_last;
    logic               w_open;
    logic [N_REQ-1:0]   w_win;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_any;
    logic [N_REQ-1:0]   w_start;
    logic [N_REQ-1:0]   w_seen_now;
    logic               w_ovr_evt;

    assign w_last     = (r_phase == PHASE_W'(FRAME_LEN - 1));
    assign w_open     = (int'(r_phase) < OPEN_LIMIT);
    assign w_seen_now = r_seen | (w_open ? i_req : '0);

    // A request raised in the guard window was never grantable this frame,
    // so only requests seen in the open part of the frame can cause an overrun.
    assign w_ovr_evt  = (r_state == RUN) && w_last &&
                        ((r_grant != '0) || ((i_req & ~r_served & w_seen_now) != '0));

    fs_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_ptr     (r_ptr),
        .i_req     (i_req),
        .o_win     (w_win),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_start     = '0;
        case (r_state)
            STARTUP: begin
                if (w_last && (r_frame_cnt == 8'(STARTUP_FRAMES - 1))) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_grant != '0) begin
                    // Only the granted requester's done ends the slot.
                    if ((i_done & r_grant) != '0) begin
                        w_grant_nxt = '0;
                    end
                end else if (w_open && w_any) begin
                    w_grant_nxt = w_win;
                    w_start     = w_win;
                    w_ptr_nxt   = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
                end
            end
            default: w_state_nxt = STARTUP;
        endcase
    end

    always_ff @(posedge i_clk_256fs) begin
        if (i_rst) begin
            r_state <= STARTUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk_256fs) begin
        if (i_rst) begin
            r_phase     <= '0;
            r_strobe    <= 1'b0;
            r_frame_cnt <= '0;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_served    <= '0;
            r_seen      <= '0;
            r_overrun   <= 1'b0;
            r_ovr_cnt   <= '0;
        end else begin
            r_phase  <= r_phase + PHASE_W'(1);
            r_strobe <= w_last;
            if ((r_state == STARTUP) && w_last) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            // A grant decided at phase 255 starts in the new frame.
            r_served <= w_last ? w_start : (r_served | w_start);
            r_seen   <= w_last ? '0 : w_seen_now;
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
                if (r_ovr_cnt != OVR_CNT_MAX) begin
                    r_ovr_cnt <= r_ovr_cnt + 8'd1;
                end
            end
        end
    end

`ifdef FS_SCHED_STATS_EN
    logic [8:0] r_busy_acc;
    logic [8:0] r_busy_cycles;
    logic [8:0] w_busy_inc;

    assign w_busy_inc = r_busy_acc + {8'd0, (r_grant != '0)};

    always_ff @(posedge i_clk_256fs) begin
        if (i_rst) begin
            r_busy_acc    <= '0;
            r_busy_cycles <= '0;
        end else if (w_last) begin
            r_busy_cycles <= w_busy_inc;
            r_busy_acc    <= '0;
        end else begin
            r_busy_acc    <= w_busy_inc;
        end
    end

    assign o_busy_cycles = r_busy_cycles;
`endif

    assign o_grant       = r_grant;
    assign o_strobe_fs   = r_strobe;
    assign o_phase       = r_phase;
    assign o_ready       = (r_state == RUN);
    assign o_overrun     = r_overrun;
    assign o_overrun_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_fs_slot_scheduler.sv
// tb_fs_slot_scheduler: directed and randomized checks of fs_slot_scheduler against a frame-level model.
// Latency: n/a.
// Backpressure: a responder pulses done a programmable number of cycles into each grant.
module tb_fs_slot_scheduler;

    localparam int N  = 4;
    localparam int SF = 2;
    localparam int GD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic         strobe;
    logic [7:0]   phase;
    logic         ready;
    logic         ovr;
    logic [7:0]   ocnt;
`ifdef FS_SCHED_STATS_EN
    logic [8:0]   busy;
`endif

    always #5 clk = ~clk;

    fs_slot_scheduler #(.N_REQ(N), .STARTUP_FRAMES(SF), .GUARD(GD)) dut (
        .i_clk_256fs   (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_done        (done),
        .o_grant       (grant),
        .o_strobe_fs   (strobe),
        .o_phase       (phase),
        .o_ready       (ready),
        .o_overrun     (ovr),
        .o_overrun_cnt (ocnt)
`ifdef FS_SCHED_STATS_EN
        ,
        .o_busy_cycles (busy)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: time since reset release, frame numbers, and per-requester
    // records of the frame in which a grant last started / a grantable request was seen.
    int m_t, m_win, m_ptr, m_cnt, m_busy_acc, m_busy;
    bit m_ovr;
    int m_start_fr[N];
    int m_seen_fr[N];

    always @(posedge clk) begin
        int  ph, fr, w;
        bit  late;
        if (rst) begin
            m_t = 0; m_win = -1; m_ptr = 0; m_cnt = 0; m_ovr = 1'b0;
            m_busy_acc = 0; m_busy = 0;
            for (int i = 0; i < N; i++) begin
                m_start_fr[i] = -1;
                m_seen_fr[i]  = -1;
            end
        end else begin
            ph = m_t % 256;
            fr = m_t / 256;
            if (ph < 256 - GD)
                for (int i = 0; i < N; i++) if (req[i]) m_seen_fr[i] = fr;
            if (m_t >= SF * 256 && ph == 255) begin
                late = (m_win >= 0);
                for (int i = 0; i < N; i++)
                    if (req[i] && m_start_fr[i] != fr && m_seen_fr[i] == fr) late = 1'b1;
                if (late) begin
                    m_ovr = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_busy_acc += (m_win >= 0) ? 1 : 0;
            if (ph == 255) begin
                m_busy = m_busy_acc;
                m_busy_acc = 0;
            end
            if (m_win >= 0) begin
                if (done[m_win]) m_win = -1;
            end else if (m_t >= SF * 256 && ph < 256 - GD && req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_win = w;
                m_ptr = (w + 1) % N;
                m_start_fr[w] = (m_t + 1) / 256;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",   32'(grant),  (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
            chk("phase",   32'(phase),  32'(m_t % 256));
            chk("strobe",  32'(strobe), 32'((m_t > 0) && (m_t % 256 == 0)));
            chk("ready",   32'(ready),  32'(m_t >= SF * 256));
            chk("overrun", 32'(ovr),    32'(m_ovr));
            chk("ovr_cnt", 32'(ocnt),   32'(m_cnt));
`ifdef FS_SCHED_STATS_EN
            chk("busy",    32'(busy),   32'(m_busy));
`endif
        end
    end

    // Stimulus: everything below runs in one process.
    bit           resp_en, drop_on_done, rand_en;
    int           resp_dly, age;
    logic [N-1:0] prev_g;

    task automatic step();
        @(negedge clk);
        done = '0;
        if (grant != '0 && grant == prev_g) age++; else age = 0;
        prev_g = grant;
        if (resp_en && grant != '0 && age >= resp_dly) begin
            done = grant;
            if (drop_on_done) req = req & ~grant;
            if (rand_en)
                resp_dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 150))
                                                       : int'($urandom_range(0, 6));
        end
        if (rand_en) begin
            if ($urandom_range(0, 7) == 0) done = done | (N'($urandom) & ~grant);
            for (int i = 0; i < N; i++)
                if (!req[i] && !grant[i] && $urandom_range(0, 15) == 0) req[i] = 1'b1;
        end
    endtask

    task automatic wait_phase(input int p, input string nm);
        int k = 0;
        while (int'(phase) != p && k < 600) begin
            step();
            k++;
        end
        chk(nm, 32'(phase), 32'(p));
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string nm);
        int k = 0;
        while (grant != g && k < 2000) begin
            step();
            k++;
        end
        chk(nm, 32'(grant), 32'(g));
    endtask

    task automatic startup_check(input string tag);
        bit any_g = 1'b0;
        bit any_r = 1'b0;
        for (int c = 1; c < SF * 256; c++) begin
            step();
            any_g |= (grant != '0);
            any_r |= ready;
        end
        chk({tag, "_no_grant"}, 32'(any_g), 32'd0);
        chk({tag, "_no_ready"}, 32'(any_r), 32'd0);
        step();
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_phase0"}, 32'(phase), 32'd0);
        step();
        chk({tag, "_first_grant"}, 32'(grant), 32'd1);
    endtask

    initial begin
        int           gs_cyc[5];
        logic [N-1:0] gs_val[5];
        logic [N-1:0] pg;
        int           ng, c;
        bit           gflag;

        rst = 1'b1; req = '0; done = '0;
        resp_en = 1'b0; drop_on_done = 1'b0; rand_en = 1'b0;
        resp_dly = 3; age = 0; prev_g = '0;

        // Startup hold with all requests raised.
        req = 4'b1111;
        step();
        chk_en = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_strobe", 32'(strobe), 32'd0);
        resp_en = 1'b1;
        resp_dly = 3;
        startup_check("startup");

        // Round-robin: done three cycles into each grant.
        gs_cyc[0] = SF * 256 + 1; gs_val[0] = grant; ng = 1; pg = grant; c = gs_cyc[0];
        while (ng < 5 && c < 1500) begin
            step();
            c++;
            if (grant != '0 && grant != pg) begin
                gs_cyc[ng] = c;
                gs_val[ng] = grant;
                ng++;
            end
            pg = grant;
        end
        chk("rr_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order_%0d", i), 32'(gs_val[i]), 32'd1 << (i % 4));
            if (i > 0) chk($sformatf("rr_spacing_%0d", i), 32'(gs_cyc[i] - gs_cyc[i-1]), 32'd5);
        end
        req = '0;
        wait_grant('0, "rr_drain");

        // Guard window: request raised at phase 249 waits for the next frame.
        drop_on_done = 1'b1;
        wait_phase(249, "guard_reach_249");
        req = 4'b0100;
        gflag = 1'b0;
        c = 0;
        do begin
            step();
            gflag |= (grant != '0);
            c++;
        end while (int'(phase) != 0 && c < 300);
        chk("guard_no_grant", 32'(gflag), 32'd0);
        step();
        chk("guard_phase1", 32'(phase), 32'd1);
        chk("guard_grant", 32'(grant), 32'b0100);
        chk("guard_no_ovr", 32'(ovr), 32'd0);
        wait_grant('0, "guard_drain");

        // Single overrun: grant at phase 200 held across the frame boundary.
        resp_en = 1'b0;
        wait_phase(199, "ovr_reach_199");
        req = 4'b0001;
        step();
        chk("ovr_grant_200", 32'(grant), 32'd1);
        wait_phase(0, "ovr_reach_0");
        chk("ovr_flag", 32'(ovr), 32'd1);
        chk("ovr_cnt1", 32'(ocnt), 32'd1);
        chk("ovr_grant_held", 32'(grant), 32'd1);
        resp_en = 1'b1;
        resp_dly = 0;
        wait_grant('0, "ovr_release");

`ifdef FS_SCHED_STATS_EN
        // One 10-cycle grant in an otherwise idle frame.
        req = '0;
        wait_phase(255, "stats_reach_255");
        step();
        wait_phase(10, "stats_reach_10");
        req = 4'b0001;
        resp_dly = 9;
        wait_phase(0, "stats_next_frame");
        chk("stats_busy_p0", 32'(busy), 32'd10);
        wait_phase(255, "stats_frame_end");
        chk("stats_busy_p255", 32'(busy), 32'd10);
`endif

        // Randomized traffic with varying service times and stray done bits.
        rand_en = 1'b1;
        repeat (2500) step();
        rand_en = 1'b0;
        req = '0;
        wait_grant('0, "rand_drain");

        // Saturation: a grant that never completes overruns every frame.
        resp_en = 1'b0;
        wait_phase(100, "sat_reach_100");
        req = 4'b0001;
        repeat (256 * 256) step();
        chk("sat_cnt", 32'(ocnt), 32'd255);
        chk("sat_flag", 32'(ovr), 32'd1);
        chk("sat_grant_held", 32'(grant), 32'd1);
        resp_en = 1'b1;
        resp_dly = 0;
        wait_grant('0, "sat_release");

        // Reset while requester 1 is granted.
        req = 4'b0010;
        resp_en = 1'b0;
        wait_grant(4'b0010, "mid_grant");
        rst = 1'b1;
        step();
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_ovr", 32'(ovr), 32'd0);
        chk("mid_rst_cnt", 32'(ocnt), 32'd0);
        step();
        rst = 1'b0;
        req = 4'b1111;
        resp_en = 1'b1;
        resp_dly = 3;
        startup_check("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
